// File: rtl/serial_loader.sv
// Host-side byte command monitor: loads/dumps RAM over the UART and launches the CPU.
// Owns the RAM and CPU start interface while the CPU is idle.
module serial_loader #(
  parameter int         AW       = 9,
  parameter logic [7:0] ACK_OK   = 8'h4B,
  parameter logic [7:0] ACK_HALT = 8'h48,
  parameter logic [7:0] NAK      = 8'h3F
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_byte,
  input  logic          received,
  output logic [7:0]    tx_byte,
  output logic          transmit,
  input  logic          is_transmitting,
  output logic [AW-1:0] ram_waddr,
  output logic [7:0]    ram_wdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_raddr,
  input  logic [7:0]    ram_rdata,
  output logic          cpu_go,
  output logic [AW-1:0] cpu_startaddr,
  input  logic          cpu_halted,
  output logic          busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDRH, S_ADDRL, S_LEN, S_LDATA, S_RADDR, S_RWAIT,
    S_RDATA, S_GOSTART, S_RUN, S_TXWAIT, S_TXGAP
  } state_t;

  typedef enum logic [1:0] {C_LOAD, C_READ, C_GO} cmd_t;

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [8:0]    cnt_q, cnt_d;
  logic          ret_rd_q, ret_rd_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          transmit_q, transmit_d;
  logic [AW-1:0] ram_waddr_q, ram_waddr_d;
  logic [7:0]    ram_wdata_q, ram_wdata_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_raddr_q, ram_raddr_d;
  logic          cpu_go_q, cpu_go_d;
  logic [AW-1:0] cpu_startaddr_q, cpu_startaddr_d;

  always_comb begin
    state_d         = state_q;
    cmd_d           = cmd_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    ret_rd_d        = ret_rd_q;
    tx_byte_d       = tx_byte_q;
    transmit_d      = 1'b0;
    ram_waddr_d     = ram_waddr_q;
    ram_wdata_d     = ram_wdata_q;
    ram_we_d        = 1'b0;
    ram_raddr_d     = ram_raddr_q;
    cpu_go_d        = 1'b0;
    cpu_startaddr_d = cpu_startaddr_q;

    case (state_q)
      S_IDLE: if (received) begin
        case (rx_byte)
          8'h4C: begin cmd_d = C_LOAD; state_d = S_ADDRH; end
          8'h52: begin cmd_d = C_READ; state_d = S_ADDRH; end
          8'h47: begin cmd_d = C_GO;   state_d = S_ADDRH; end
          default: begin
            tx_byte_d = NAK;
            ret_rd_d  = 1'b0;
            state_d   = S_TXWAIT;
          end
        endcase
      end
      // Only ADDRH[0] survives the truncation to AW bits.
      S_ADDRH: if (received) begin
        addr_d  = AW'({rx_byte, 8'h00});
        state_d = S_ADDRL;
      end
      S_ADDRL: if (received) begin
        addr_d = {addr_q[AW-1:8], rx_byte};
        if (cmd_q == C_GO) begin
          cpu_startaddr_d = {addr_q[AW-1:8], rx_byte};
          state_d         = S_GOSTART;
        end else begin
          state_d = S_LEN;
        end
      end
      S_LEN: if (received) begin
        cnt_d = (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
        if (cmd_q == C_LOAD) begin
          state_d = S_LDATA;
        end else begin
          ram_raddr_d = addr_q;
          state_d     = S_RADDR;
        end
      end
      S_LDATA: if (received) begin
        ram_we_d    = 1'b1;
        ram_waddr_d = addr_q;
        ram_wdata_d = rx_byte;
        addr_d      = addr_q + AW'(1);
        cnt_d       = cnt_q - 9'd1;
        if (cnt_q == 9'd1) begin
          tx_byte_d = ACK_OK;
          ret_rd_d  = 1'b0;
          state_d   = S_TXWAIT;
        end
      end
      // Read data arrives two cycles after the address: RADDR, RWAIT, then RDATA.
      S_RADDR: state_d = S_RWAIT;
      S_RWAIT: state_d = S_RDATA;
      S_RDATA: begin
        tx_byte_d = ram_rdata;
        addr_d    = addr_q + AW'(1);
        cnt_d     = cnt_q - 9'd1;
        ret_rd_d  = (cnt_q != 9'd1);
        state_d   = S_TXWAIT;
      end
      S_GOSTART: begin
        cpu_go_d = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN: if (cpu_halted) begin
        tx_byte_d = ACK_HALT;
        ret_rd_d  = 1'b0;
        state_d   = S_TXWAIT;
      end
      S_TXWAIT: if (!is_transmitting) begin
        transmit_d = 1'b1;
        state_d    = S_TXGAP;
      end
      // One dead cycle lets the transmitter's busy flag rise before the next check.
      S_TXGAP: begin
        if (ret_rd_q) begin
          ram_raddr_d = addr_q;
          state_d     = S_RADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cmd_q           <= C_LOAD;
      addr_q          <= '0;
      cnt_q           <= '0;
      ret_rd_q        <= 1'b0;
      tx_byte_q       <= '0;
      transmit_q      <= 1'b0;
      ram_waddr_q     <= '0;
      ram_wdata_q     <= '0;
      ram_we_q        <= 1'b0;
      ram_raddr_q     <= '0;
      cpu_go_q        <= 1'b0;
      cpu_startaddr_q <= '0;
    end else begin
      state_q         <= state_d;
      cmd_q           <= cmd_d;
      addr_q          <= addr_d;
      cnt_q           <= cnt_d;
      ret_rd_q        <= ret_rd_d;
      tx_byte_q       <= tx_byte_d;
      transmit_q      <= transmit_d;
      ram_waddr_q     <= ram_waddr_d;
      ram_wdata_q     <= ram_wdata_d;
      ram_we_q        <= ram_we_d;
      ram_raddr_q     <= ram_raddr_d;
      cpu_go_q        <= cpu_go_d;
      cpu_startaddr_q <= cpu_startaddr_d;
    end
  end

  assign tx_byte       = tx_byte_q;
  assign transmit      = transmit_q;
  assign ram_waddr     = ram_waddr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_we        = ram_we_q;
  assign ram_raddr     = ram_raddr_q;
  assign cpu_go        = cpu_go_q;
  assign cpu_startaddr = cpu_startaddr_q;
  assign busy          = (state_q != S_IDLE);

endmodule
